fact_core_regfile: RTL
======================

Name: fact_core_regfile

Overview:
- Downstream consumer of the address-decoded, write-enable-gated register strobes (7 one-hot strobes) in the FactoCore slave.
- Holds the 7 FactoCore registers: OPSTART, OPCLEAR, OPDONE, INTRENABLE, OPERAND, RESULT_H, RESULT_L.
- Runs a multi-cycle factorial engine: repeated multiply using a sequential shift-add multiplier.
- Drives the interrupt line and exposes all register values to the read mux.

Parameters:
- DW, 64, data bus / register width.
- MUL_CYC, 64, cycles per multiply. Must equal DW; fixed by the shift-add multiplier.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- to_reg  in  7  write strobes; bit i writes register i, already gated by we.
- din  in  DW  write data.
- opstart  out  DW  OPSTART register.
- opclear  out  DW  OPCLEAR register.
- opdone  out  DW  OPDONE register; bit0 done, bit1 busy, others 0.
- intr_en  out  DW  INTRENABLE register.
- operand  out  DW  OPERAND register.
- result_h  out  DW  upper half of 2*DW-bit result.
- result_l  out  DW  lower half of result.
- interrupt  out  1  opdone[0] & intr_en[0].

Behaviour:
- Reset (async, reset_n=0): all register outputs 0, interrupt 0, FSM in IDLE, multiplier cleared.
- Writes take effect on the rising edge where the strobe is high.
- OPSTART, OPCLEAR, INTRENABLE, OPERAND are writable. OPDONE, RESULT_H and RESULT_L ignore writes.
- Strobe priority if more than one bit is set: OPCLEAR > OPSTART > others. The other writes in the same cycle still apply, except OPERAND/OPSTART while busy.
- OPCLEAR write with din[0]=1:
  - Synchronously returns every register, the FSM and the multiplier to reset values, including a running operation (abort).
  - The OPCLEAR register itself holds 0 afterwards.
  - din[0]=0 has no effect.
- OPSTART write with din[0]=1 in IDLE: launches the operation. Writes to OPSTART while busy are ignored.
- OPERAND writes while busy are ignored. The engine uses the value latched in INIT.
- FSM states: IDLE, INIT, MULT, DONE.
  - IDLE: on start, go to INIT. OPSTART register := din; opdone := 0.
  - INIT (1 cycle): acc := 1, cnt := operand, opdone[1] := 1. If cnt <= 1, go to DONE; else go to MULT.
  - MULT: the multiplier computes acc := (acc * cnt) mod 2^(2*DW) in MUL_CYC cycles. On completion, cnt := cnt-1. If the new cnt <= 1, go to DONE; else start the next multiply on the following cycle.
  - DONE (1 cycle): result_h/result_l := acc; opdone := 1 (done=1, busy=0); go to IDLE.
- Latency, start edge to opdone[0]=1: 2 cycles for operand 0 or 1; 2 + MUL_CYC*(operand-1) cycles otherwise.
- Results wrap modulo 2^128 for operand >= 35.
- opdone[0] stays 1 until OPCLEAR or the next start.
- interrupt is combinational from the registers and is high one cycle after DONE.

Optional Feature:
- Macro: FACT_EARLY_TERM_EN.
- Defined: the multiplier finishes as soon as the remaining (right-shifted) multiplier bits are all zero. Each multiply takes max(1, bit-length of cnt) cycles. Results are identical; latency shrinks.
- Undefined: fixed MUL_CYC cycles per multiply; latency exactly as stated above.

Decomposition:
- Package fact_pkg holds:
  - register index localparams: OPSTART=0, OPCLEAR=1, OPDONE=2, INTRENABLE=3, OPERAND=4, RESULT_H=5, RESULT_L=6;
  - FSM state encoding;
  - DW default.
- One sub-module, fact_seq_mul:
  - ports: clk, reset_n, start, clear, multiplicand (2*DW), multiplier (DW), product (2*DW), done;
  - radix-2 shift-add, done pulsed 1 cycle.

Test Plan:
- Reset mid-MULT (reset_n low 1 cycle) -> all outputs 0, interrupt 0, FSM IDLE; later start runs normally.
- operand=5, intr_en=1, start -> opdone=1 after exactly 258 cycles; result_l=120, result_h=0; interrupt=1.
- operand=0 then operand=1, each with start -> opdone=1 after 2 cycles; result_l=1.
- operand=20 -> result_l=0x21C3677C82B40000, result_h=0, after 2+64*19 cycles (fewer with FACT_EARLY_TERM_EN, same value).
- operand=10, start; OPERAND write 3 and OPSTART write at cycle 50 -> both ignored; result_l=3628800.
- OPCLEAR din=1 at cycle 100 of operand=10 run -> next cycle all registers 0, busy=0, no interrupt; subsequent operand=4 start yields 24.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared definitions for the FactoCore register file: register indices,
// engine FSM encoding and the default datapath width.
package fact_pkg;
  localparam int FACT_DW = 64;

  localparam int OPSTART    = 0;
  localparam int OPCLEAR    = 1;
  localparam int OPDONE     = 2;
  localparam int INTRENABLE = 3;
  localparam int OPERAND    = 4;
  localparam int RESULT_H   = 5;
  localparam int RESULT_L   = 6;
  localparam int NUM_REGS   = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_MULT = 2'd2,
    ST_DONE = 2'd3
  } fact_state_e;
endpackage

// File: rtl/fact_seq_mul.sv
// Radix-2 shift-add multiplier: 2*DW-bit multiplicand times DW-bit multiplier,
// result mod 2^(2*DW). Optional FACT_EARLY_TERM_EN stops once multiplier bits run out.
module fact_seq_mul
  import fact_pkg::*;
#(
  parameter int DW    = FACT_DW,
  parameter int NSTEP = DW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            clear,
  input  logic [2*DW-1:0] multiplicand,
  input  logic [DW-1:0]   multiplier,
  output logic [2*DW-1:0] product,
  output logic            done
);
  localparam int SW = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  logic [2*DW-1:0] mc_q, p_q, mc_c, p_c;
  logic [DW-1:0]   mp_q, mp_c;
  logic [SW-1:0]   step_q, step_c;
  logic            busy_q, active;

  // start feeds the operands straight into the first step so back-to-back
  // multiplies lose no cycle; product/done are valid in the finishing cycle.
  always_comb begin
    active  = start | busy_q;
    mc_c    = start ? multiplicand : mc_q;
    mp_c    = start ? multiplier : mp_q;
    p_c     = start ? '0 : p_q;
    step_c  = start ? '0 : step_q;
    product = p_c + (mp_c[0] ? mc_c : '0);
`ifdef FACT_EARLY_TERM_EN
    done    = active && (((mp_c >> 1) == '0) || (step_c == SW'(NSTEP - 1)));
`else
    done    = active && (step_c == SW'(NSTEP - 1));
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mc_q <= '0; mp_q <= '0; p_q <= '0; step_q <= '0; busy_q <= 1'b0;
    end else if (clear) begin
      mc_q <= '0; mp_q <= '0; p_q <= '0; step_q <= '0; busy_q <= 1'b0;
    end else if (active) begin
      p_q    <= product;
      mc_q   <= mc_c << 1;
      mp_q   <= mp_c >> 1;
      step_q <= step_c + 1'b1;
      busy_q <= ~done;
    end
  end
endmodule

// File: rtl/fact_core_regfile.sv
// FactoCore register file and factorial engine (repeated shift-add multiply).
// Optional build macro: FACT_EARLY_TERM_EN (multiplies end early on small counts).
module fact_core_regfile
  import fact_pkg::*;
#(
  parameter int DW      = FACT_DW,
  parameter int MUL_CYC = DW
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REGS-1:0] to_reg,
  input  logic [DW-1:0]       din,
  output logic [DW-1:0]       opstart,
  output logic [DW-1:0]       opclear,
  output logic [DW-1:0]       opdone,
  output logic [DW-1:0]       intr_en,
  output logic [DW-1:0]       operand,
  output logic [DW-1:0]       result_h,
  output logic [DW-1:0]       result_l,
  output logic                interrupt
);
  fact_state_e state_q, state_d;

  logic [2*DW-1:0] acc_q, product;
  logic [DW-1:0]   cnt_q, cnt_dec;
  logic            launch_q, mul_done, mul_start;
  logic            clr, busy, start, ld_init, in_mult, ld_done;

  assign clr     = to_reg[OPCLEAR] & din[0];
  assign busy    = (state_q != ST_IDLE);
  assign start   = to_reg[OPSTART] & din[0] & ~busy & ~clr;
  assign cnt_dec = cnt_q - 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_INIT;
      ST_INIT: state_d = (operand <= DW'(1)) ? ST_DONE : ST_MULT;
      ST_MULT: if (mul_done && (cnt_dec <= DW'(1))) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clr) state_d = ST_IDLE;
  end

  always_comb begin
    ld_init   = (state_q == ST_INIT);
    in_mult   = (state_q == ST_MULT);
    ld_done   = (state_q == ST_DONE);
    mul_start = in_mult & launch_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opstart <= '0; opclear <= '0; opdone <= '0; intr_en <= '0; operand <= '0;
      result_h <= '0; result_l <= '0; acc_q <= '0; cnt_q <= '0; launch_q <= 1'b0;
    end else if (clr) begin
      opstart <= '0; opclear <= '0; opdone <= '0; intr_en <= '0; operand <= '0;
      result_h <= '0; result_l <= '0; acc_q <= '0; cnt_q <= '0; launch_q <= 1'b0;
    end else begin
      if (to_reg[OPCLEAR])             opclear <= din;
      if (to_reg[INTRENABLE])          intr_en <= din;
      if (to_reg[OPERAND] && !busy)    operand <= din;
      if (to_reg[OPSTART] && !busy)    opstart <= din;
      if (start)                       opdone  <= '0;
      if (ld_init) begin
        acc_q    <= (2*DW)'(1);
        cnt_q    <= operand;
        opdone   <= DW'(2);
        launch_q <= (operand > DW'(1));
      end
      if (in_mult) begin
        launch_q <= 1'b0;
        if (mul_done) begin
          acc_q    <= product;
          cnt_q    <= cnt_dec;
          launch_q <= (cnt_dec > DW'(1));
        end
      end
      if (ld_done) begin
        result_h <= acc_q[2*DW-1:DW];
        result_l <= acc_q[DW-1:0];
        opdone   <= DW'(1);
      end
    end
  end

  fact_seq_mul #(.DW(DW), .NSTEP(MUL_CYC)) u_mul (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (mul_start),
    .clear        (clr),
    .multiplicand (acc_q),
    .multiplier   (cnt_q),
    .product      (product),
    .done         (mul_done)
  );

  assign interrupt = opdone[0] & intr_en[0];
endmodule
